out_channel_drain: RTL and testbench

Drains the test program's output channel to a host-side consumer. The executing program pushes one word per `out` instruction; this block buffers the words in a ring and presents them on a valid/ready stream in push order. When the program signals `finished`, the block flushes the ring and asserts `drained` once the last word has been accepted. It sits between the `fpga` program core and whatever reads results off-chip or into a checker.

---
 rtl/fpga_pkg.sv | 10 +
 rtl/channel_ring.sv | 70 +++++++
 rtl/out_channel_drain.sv | 111 +++++++++++
 tb/tb_out_channel_drain.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_pkg.sv
// Shared types and defaults for the fpga program core and its output-channel plumbing.
package fpga_pkg;

  localparam int MemoryElementWidthDefault = 12;

  typedef enum logic [1:0] {RUN, FLUSH, DONE} drain_state_t;

  typedef logic [MemoryElementWidthDefault-1:0] word_t;

endpackage

// File: rtl/channel_ring.sv
// Policy-free ring buffer: applies the push/pop strobes it is given and exposes occupancy and head word.
module channel_ring #(
  parameter int W  = 12,
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  rdata_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // N need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(N - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [W-1:0]  mem_q [N];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    if (push_i) begin
      tail_d = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end
    if (pop_i) begin
      head_d = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not cleared on reset.
  always_ff @(posedge clock) begin
    if (push_i && !reset) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

  assign count_o = count_q;
  assign rdata_o = mem_q[head_q];

endmodule

// File: rtl/out_channel_drain.sv
// Buffers words pushed by the program's out instructions and streams them to a consumer,
// flushing and then signalling drained once the program has finished.
module out_channel_drain
  import fpga_pkg::*;
#(
  parameter int MemoryElementWidth = MemoryElementWidthDefault,
  parameter int NOut               = 8,
  parameter int CountWidth         = $clog2(NOut + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          outWrite,
  input  logic [MemoryElementWidth-1:0] outData,
  input  logic                          finished,
  output logic                          rdValid,
  output logic [MemoryElementWidth-1:0] rdData,
  input  logic                          rdReady,
  output logic [CountWidth-1:0]         count,
  output logic [15:0]                   pushed,
  output logic                          overflow,
  output logic                          drained
);

  drain_state_t          state_q, state_d;
  logic [CountWidth-1:0] count_s, count_next_s;
  logic                  pop_s, accept_s;
  logic [15:0]           pushed_q, pushed_d;
  logic                  overflow_q, overflow_d;
  logic                  drained_q, drained_d;

  channel_ring #(
    .W  (MemoryElementWidth),
    .N  (NOut),
    .CW (CountWidth)
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .push_i  (accept_s),
    .pop_i   (pop_s),
    .wdata_i (outData),
    .count_o (count_s),
    .rdata_o (rdData)
  );

  assign rdValid = (count_s != {CountWidth{1'b0}});
  assign pop_s   = rdValid && rdReady;

  // A full ring still takes a push when the same cycle frees a slot.
  always_comb begin
    accept_s = 1'b0;
    if (outWrite && (state_q != DONE)) begin
      accept_s = (count_s < CountWidth'(NOut)) || pop_s;
    end else begin
      accept_s = 1'b0;
    end
    count_next_s = count_s + CountWidth'(accept_s) - CountWidth'(pop_s);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (finished) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if ((count_next_s == {CountWidth{1'b0}}) && !accept_s) begin
          state_d = DONE;
        end else begin
          state_d = FLUSH;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pushed_d   = pushed_q;
    overflow_d = overflow_q || (outWrite && !accept_s);
    drained_d  = drained_q || (state_d == DONE);
    if (accept_s && (pushed_q != 16'hFFFF)) begin
      pushed_d = pushed_q + 16'd1;
    end else begin
      pushed_d = pushed_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      pushed_q   <= 16'd0;
      overflow_q <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pushed_q   <= pushed_d;
      overflow_q <= overflow_d;
      drained_q  <= drained_d;
    end
  end

  assign count    = count_s;
  assign pushed   = pushed_q;
  assign overflow = overflow_q;
  assign drained  = drained_q;

endmodule

// File: tb/tb_out_channel_drain.sv
// Directed bench for out_channel_drain: an 8-deep instance for the main sequences and a 5-deep one for wrap-around.
module tb_out_channel_drain;

  logic        clock = 1'b0;
  logic        reset;

  logic        a_outWrite, a_finished, a_rdReady;
  logic [11:0] a_outData;
  logic        a_rdValid, a_overflow, a_drained;
  logic [11:0] a_rdData;
  logic [3:0]  a_count;
  logic [15:0] a_pushed;

  logic        b_outWrite, b_finished, b_rdReady;
  logic [11:0] b_outData;
  logic        b_rdValid, b_overflow, b_drained;
  logic [11:0] b_rdData;
  logic [2:0]  b_count;
  logic [15:0] b_pushed;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  out_channel_drain #(.MemoryElementWidth(12), .NOut(8)) dut_a (
    .clock(clock), .reset(reset), .outWrite(a_outWrite), .outData(a_outData),
    .finished(a_finished), .rdValid(a_rdValid), .rdData(a_rdData), .rdReady(a_rdReady),
    .count(a_count), .pushed(a_pushed), .overflow(a_overflow), .drained(a_drained)
  );

  out_channel_drain #(.MemoryElementWidth(12), .NOut(5)) dut_b (
    .clock(clock), .reset(reset), .outWrite(b_outWrite), .outData(b_outData),
    .finished(b_finished), .rdValid(b_rdValid), .rdData(b_rdData), .rdReady(b_rdReady),
    .count(b_count), .pushed(b_pushed), .overflow(b_overflow), .drained(b_drained)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed only after this returns, outputs are sampled here.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_a(input logic [11:0] d);
    a_outWrite = 1'b1;
    a_outData  = d;
    step();
    a_outWrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [11:0] q[$];
  int          k, got, cyc;
  logic        pop_m, wr_m;

  initial begin
    reset = 1'b1;
    a_outWrite = 1'b0; a_outData = 12'd0; a_finished = 1'b0; a_rdReady = 1'b0;
    b_outWrite = 1'b0; b_outData = 12'd0; b_finished = 1'b0; b_rdReady = 1'b0;
    step();
    reset = 1'b0;

    chk("rst_count", a_count, 0);
    chk("rst_valid", a_rdValid, 0);
    chk("rst_pushed", a_pushed, 0);
    chk("rst_overflow", a_overflow, 0);
    chk("rst_drained", a_drained, 0);

    // Wrap-around on the 5-deep instance: 20 words, interleaved push/pop, modelled with a queue.
    k = 0; got = 0; cyc = 0;
    while ((got < 20) && (cyc < 400)) begin
      b_rdReady = (cyc % 2 == 1) || (k >= 20);
      pop_m     = (q.size() != 0) && b_rdReady;
      wr_m      = (k < 20) && (cyc % 3 != 2) && ((q.size() < 5) || pop_m);
      b_outWrite = wr_m;
      b_outData  = 12'(100 + k);
      if (pop_m) begin
        chk("wrap_data", b_rdData, q.pop_front());
        got++;
      end
      if (wr_m) begin
        q.push_back(12'(100 + k));
        k++;
      end
      step();
      chk("wrap_count", b_count, q.size());
      cyc++;
    end
    b_outWrite = 1'b0; b_rdReady = 1'b0;
    chk("wrap_received", got, 20);
    chk("wrap_overflow", b_overflow, 0);
    chk("wrap_pushed", b_pushed, 20);

    // Three pushes held, then streamed out one per cycle.
    push_a(12'd5); push_a(12'd7); push_a(12'd9);
    chk("p3_count", a_count, 3);
    chk("p3_valid", a_rdValid, 1);
    chk("p3_data0", a_rdData, 5);
    a_rdReady = 1'b1;
    step();
    chk("p3_data1", a_rdData, 7);
    step();
    chk("p3_data2", a_rdData, 9);
    step();
    chk("p3_empty_valid", a_rdValid, 0);
    chk("p3_empty_count", a_count, 0);
    chk("p3_pushed", a_pushed, 3);
    a_rdReady = 1'b0;

    // Fill to capacity, drop one, then push-with-pop at full.
    do_reset();
    for (int i = 1; i <= 8; i++) push_a(12'(i));
    chk("full_count", a_count, 8);
    chk("full_overflow_clear", a_overflow, 0);
    push_a(12'd9);
    chk("drop_overflow", a_overflow, 1);
    chk("drop_count", a_count, 8);
    chk("drop_pushed", a_pushed, 8);
    a_rdReady = 1'b1;
    chk("full_head", a_rdData, 1);
    push_a(12'd10);
    chk("fullpp_count", a_count, 8);
    chk("fullpp_pushed", a_pushed, 9);
    for (int i = 2; i <= 9; i++) begin
      chk("fullpp_seq", a_rdData, (i == 9) ? 10 : i);
      step();
    end
    chk("fullpp_empty", a_rdValid, 0);
    a_rdReady = 1'b0;

    // Finish with 2 buffered plus a same-cycle push.
    do_reset();
    push_a(12'h011); push_a(12'h022);
    a_finished = 1'b1;
    push_a(12'd4);
    chk("fin_count", a_count, 3);
    chk("fin_drained0", a_drained, 0);
    chk("fin_head", a_rdData, 12'h011);
    a_rdReady = 1'b1;
    step();
    chk("fin_data1", a_rdData, 12'h022);
    chk("fin_drained1", a_drained, 0);
    step();
    chk("fin_data2", a_rdData, 4);
    chk("fin_drained2", a_drained, 0);
    step();
    chk("fin_drained3", a_drained, 1);
    chk("fin_count_end", a_count, 0);
    chk("fin_valid_end", a_rdValid, 0);
    a_rdReady = 1'b0;
    chk("fin_overflow0", a_overflow, 0);
    push_a(12'd6);
    chk("done_overflow", a_overflow, 1);
    chk("done_count", a_count, 0);
    chk("done_pushed", a_pushed, 3);
    chk("done_drained_hold", a_drained, 1);

    // Finish with an empty ring.
    a_finished = 1'b0;
    do_reset();
    chk("empty_drained_pre", a_drained, 0);
    a_finished = 1'b1;
    step();
    step();
    chk("empty_drained", a_drained, 1);
    a_finished = 1'b0;

    // Reset mid-stream with 4 buffered and an overflow recorded.
    do_reset();
    for (int i = 1; i <= 9; i++) push_a(12'(i + 32));
    a_rdReady = 1'b1;
    for (int i = 0; i < 4; i++) step();
    a_rdReady = 1'b1;
    chk("mid_count_pre", a_count, 4);
    chk("mid_overflow_pre", a_overflow, 1);
    chk("mid_pushed_pre", a_pushed, 8);
    reset = 1'b1;
    a_outWrite = 1'b1;
    a_outData = 12'd77;
    step();
    reset = 1'b0;
    a_outWrite = 1'b0;
    a_rdReady = 1'b0;
    chk("mid_count", a_count, 0);
    chk("mid_valid", a_rdValid, 0);
    chk("mid_pushed", a_pushed, 0);
    chk("mid_overflow", a_overflow, 0);
    chk("mid_drained", a_drained, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
